// File: rtl/latch_write_scheduler_pkg.sv
// Shared definitions for the latch write scheduler and related controllers.
package latch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Width of the strobe-length counter; covers STROBE_CYC up to 15.
  localparam int STROBE_W = 4;

endpackage

// File: rtl/latch_write_scheduler_if.sv
// Requester and latch-bank signals of the latch write scheduler.
interface latch_write_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8,
  parameter int AW      = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] wr_addr;
  logic [NUM_REQ*DW-1:0] wr_data;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    ack;
  logic                  le;
  logic [AW-1:0]         le_addr;
  logic [DW-1:0]         le_data;
  logic                  busy;

  // Requester/bank side.
  modport master (
    output req, wr_addr, wr_data,
    input  gnt, ack, le, le_addr, le_data, busy
  );

  // Scheduler side.
  modport slave (
    input  req, wr_addr, wr_data,
    output gnt, ack, le, le_addr, le_data, busy
  );
endinterface

// File: rtl/latch_write_scheduler_rr_picker.sv
// Rotating-priority selector: first set request at or above rr_ptr, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any_req
);

  int   j;
  logic found;

  // Scan from the pointer upward modulo N and take the first requester.
  always_comb begin
    onehot  = '0;
    idx     = '0;
    found   = 1'b0;
    j       = 0;
    any_req = |req;
    for (int k = 0; k < N; k++) begin
      j = (int'(rr_ptr) + k) % N;
      if (!found && req[j[PW-1:0]]) begin
        found              = 1'b1;
        onehot[j[PW-1:0]]  = 1'b1;
        idx                = j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/latch_write_scheduler.sv
// Round-robin writer arbitration for a shared latch bank with a
// SETUP -> STROBE -> HOLD latch-enable sequence; all outputs registered.
module latch_write_scheduler
  import latch_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DW         = 8,
  parameter int AW         = 2,
  parameter int STROBE_CYC = 2
) (
  input logic                     clk,
  input logic                     rst,
  latch_write_scheduler_if.slave  bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state, state_n;
  logic [NUM_REQ-1:0]   gnt_q, gnt_n;
  logic [NUM_REQ-1:0]   ack_q, ack_n;
  logic                 le_q, le_n;
  logic                 busy_q, busy_n;
  logic [AW-1:0]        addr_q, addr_n;
  logic [DW-1:0]        data_q, data_n;
  logic [STROBE_W-1:0]  cnt_q, cnt_n;
  logic [PW-1:0]        rr_q, rr_n;
  logic [PW-1:0]        win_q, win_n;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [PW-1:0]        pick_idx;
  logic                 any_req;

  rr_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_q),
    .onehot  (pick_oh),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    ack_n   = '0;
    le_n    = 1'b0;
    addr_n  = addr_q;
    data_n  = data_q;
    cnt_n   = cnt_q;
    rr_n    = rr_q;
    win_n   = win_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n = SETUP;
          gnt_n   = pick_oh;
          win_n   = pick_idx;
          addr_n  = bus.wr_addr[int'(pick_idx)*AW +: AW];
          data_n  = bus.wr_data[int'(pick_idx)*DW +: DW];
        end
      end
      SETUP: begin
        state_n = STROBE;
        le_n    = 1'b1;
        cnt_n   = STROBE_W'(STROBE_CYC - 1);
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_n = HOLD;
          ack_n   = gnt_q;
        end else begin
          le_n  = 1'b1;
          cnt_n = cnt_q - STROBE_W'(1);
        end
      end
      HOLD: begin
        state_n = IDLE;
        gnt_n   = '0;
        rr_n    = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + PW'(1);
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset aborts any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_q  <= '0;
      ack_q  <= '0;
      le_q   <= 1'b0;
      busy_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      rr_q   <= '0;
      win_q  <= '0;
    end else begin
      state  <= state_n;
      gnt_q  <= gnt_n;
      ack_q  <= ack_n;
      le_q   <= le_n;
      busy_q <= busy_n;
      addr_q <= addr_n;
      data_q <= data_n;
      cnt_q  <= cnt_n;
      rr_q   <= rr_n;
      win_q  <= win_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.le      = le_q;
  assign bus.busy    = busy_q;
  assign bus.le_addr = addr_q;
  assign bus.le_data = data_q;

endmodule

// File: tb/tb_latch_write_scheduler.sv
// Directed bench for latch_write_scheduler (STROBE_CYC=2 and STROBE_CYC=1 builds).
module tb_latch_write_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  latch_write_scheduler_if #(.NUM_REQ(4), .DW(8), .AW(2)) bus0 ();
  latch_write_scheduler_if #(.NUM_REQ(4), .DW(8), .AW(2)) bus1 ();

  latch_write_scheduler #(
    .NUM_REQ(4), .DW(8), .AW(2), .STROBE_CYC(2)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  latch_write_scheduler #(
    .NUM_REQ(4), .DW(8), .AW(2), .STROBE_CYC(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction on dut0 starting with dut0 in IDLE and req applied:
  // SETUP, STROBE, STROBE, HOLD, IDLE.
  task automatic txn(input string tag, input logic [3:0] g, input logic [1:0] a,
                     input logic [7:0] d, input logic [31:0] data_after, input bit drop);
    for (int p = 0; p < 5; p++) begin
      @(posedge clk); #1;
      check({tag, "_gnt"},    32'(bus0.gnt), (p < 4) ? 32'(g) : 32'd0);
      check({tag, "_onehot"}, 32'($countones(bus0.gnt) <= 1), 32'd1);
      check({tag, "_le"},     32'(bus0.le), (p == 1 || p == 2) ? 32'd1 : 32'd0);
      check({tag, "_ack"},    32'(bus0.ack), (p == 3) ? 32'(g) : 32'd0);
      check({tag, "_busy"},   32'(bus0.busy), (p < 4) ? 32'd1 : 32'd0);
      if (p >= 1 && p <= 3) begin
        check({tag, "_addr"}, 32'(bus0.le_addr), 32'(a));
        check({tag, "_data"}, 32'(bus0.le_data), 32'(d));
      end
      if (p == 1) bus0.wr_data = data_after;
      if (p == 3 && drop) bus0.req = bus0.req & ~g;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus0.req = '0; bus0.wr_addr = '0; bus0.wr_data = '0;
    bus1.req = '0; bus1.wr_addr = '0; bus1.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",  32'(bus0.gnt),     32'd0);
    check("rst_ack",  32'(bus0.ack),     32'd0);
    check("rst_le",   32'(bus0.le),      32'd0);
    check("rst_addr", 32'(bus0.le_addr), 32'd0);
    check("rst_data", 32'(bus0.le_data), 32'd0);
    check("rst_busy", 32'(bus0.busy),    32'd0);
    check("rst1_le",  32'(bus1.le),      32'd0);
    rst = 1'b0;

    // Single write from requester 1.
    bus0.wr_addr = 8'h0C;
    bus0.wr_data = 32'h0000A500;
    bus0.req     = 4'b0010;
    txn("single", 4'b0010, 2'd3, 8'hA5, 32'h0000A500, 1'b1);

    // All requesters continuously requesting from reset.
    bus0.wr_addr = 8'hE4;
    bus0.wr_data = 32'h13121110;
    bus0.req     = 4'b1111;
    pulse_reset();
    for (int i = 0; i < 5; i++)
      txn("rr", 4'(1 << (i % 4)), 2'(i % 4), 8'(8'h10 + (i % 4)), 32'h13121110, 1'b0);
    bus0.req = '0;
    pulse_reset();

    // Data changed by requester 2 after capture must not propagate.
    bus0.wr_addr = 8'h10;
    bus0.wr_data = 32'h003C0000;
    bus0.req     = 4'b0100;
    txn("capture", 4'b0100, 2'd1, 8'h3C, 32'h00FF0000, 1'b1);

    // rr_ptr is now 3: requesters 0 and 2 give wrap to 0, then 2.
    bus0.wr_addr = 8'h21;
    bus0.wr_data = 32'h00220011;
    bus0.req     = 4'b0101;
    txn("wrap0", 4'b0001, 2'd1, 8'h11, 32'h00220011, 1'b1);
    txn("skip2", 4'b0100, 2'd2, 8'h22, 32'h00220011, 1'b1);
    // Pointer back at 3: requester 3 beats requester 0.
    bus0.wr_addr = 8'hC1;
    bus0.wr_data = 32'h33000011;
    bus0.req     = 4'b1001;
    txn("ptr3", 4'b1000, 2'd3, 8'h33, 32'h33000011, 1'b1);
    txn("ptr0", 4'b0001, 2'd1, 8'h11, 32'h33000011, 1'b1);

    // Reset on the first le cycle aborts the write.
    bus0.wr_addr = 8'h04;
    bus0.wr_data = 32'h00005A00;
    bus0.req     = 4'b0010;
    @(posedge clk); #1;
    check("abort_gnt0", 32'(bus0.gnt), 32'h2);
    @(posedge clk); #1;
    check("abort_le1", 32'(bus0.le), 32'd1);
    rst      = 1'b1;
    bus0.req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_le",   32'(bus0.le),   32'd0);
    check("abort_gnt",  32'(bus0.gnt),  32'd0);
    check("abort_busy", 32'(bus0.busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_noack", 32'(bus0.ack),  32'd0);
      check("abort_idle",  32'(bus0.busy), 32'd0);
    end
    bus0.wr_addr = 8'hC0;
    bus0.wr_data = 32'h77000000;
    bus0.req     = 4'b1000;
    txn("after_rst", 4'b1000, 2'd3, 8'h77, 32'h77000000, 1'b1);

    // STROBE_CYC=1 build: le for one cycle, four-cycle occupancy.
    bus1.wr_addr = 8'h02;
    bus1.wr_data = 32'h000000C3;
    bus1.req     = 4'b0001;
    for (int p = 0; p < 4; p++) begin
      @(posedge clk); #1;
      check("s1_gnt",  32'(bus1.gnt),  (p < 3) ? 32'd1 : 32'd0);
      check("s1_le",   32'(bus1.le),   (p == 1) ? 32'd1 : 32'd0);
      check("s1_ack",  32'(bus1.ack),  (p == 2) ? 32'd1 : 32'd0);
      check("s1_busy", 32'(bus1.busy), (p < 3) ? 32'd1 : 32'd0);
      if (p == 1) begin
        check("s1_addr", 32'(bus1.le_addr), 32'd2);
        check("s1_data", 32'(bus1.le_data), 32'hC3);
      end
      if (p == 2) bus1.req = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
